// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the instruction-fetch
// port (IF) and the data-memory port (DM). DM normally wins; a starvation
// counter forces an IF grant after MAX_WAIT consecutive DM grants that IF
// had to sit through. Each transaction runs IDLE -> BUSY -> DONE.
module mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ack,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_wstrb,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_ack,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready,
  output logic                busy,
  output logic                owner
);

  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] wait_cnt;
  logic       pick_dm;

  // DM wins whenever it asks, unless IF has already waited out MAX_WAIT DM grants.
  always_comb begin
    pick_dm = dm_req && !(if_req && (wait_cnt == WAIT_LIMIT));
  end

  // Arbitration FSM; the mem_* outputs are the latched request of the owner.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      owner     <= 1'b0;
      busy      <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (if_req || dm_req) begin
            state   <= BUSY;
            busy    <= 1'b1;
            mem_req <= 1'b1;
            if (pick_dm) begin
              owner     <= 1'b1;
              mem_we    <= dm_we;
              mem_addr  <= dm_addr;
              mem_wdata <= dm_wdata;
              mem_wstrb <= dm_wstrb;
              if (!if_req) begin
                wait_cnt <= '0;
              end else if (wait_cnt != WAIT_LIMIT) begin
                wait_cnt <= wait_cnt + 4'd1;
              end
            end else begin
              owner     <= 1'b0;
              mem_we    <= 1'b0;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
              mem_wstrb <= '0;
              wait_cnt  <= '0;
            end
          end else begin
            wait_cnt <= '0;
          end
        end
        BUSY: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            state   <= DONE;
            if (owner) begin
              dm_ack <= 1'b1;
              if (!mem_we) begin
                dm_rdata <= mem_rdata;
              end
            end else begin
              if_ack   <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end
        end
        DONE: begin
          if_ack <= 1'b0;
          dm_ack <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          mem_req <= 1'b0;
          if_ack  <= 1'b0;
          dm_ack  <= 1'b0;
        end
      endcase
    end
  end

endmodule
